// File: rtl/ama_riscv_hazard_ctrl.sv
// rtl/ama_riscv_hazard_ctrl.sv - load-use, DMEM-wait and redirect hazard controller
module ama_riscv_hazard_ctrl #(
    parameter int FLUSH_DEPTH = 1,
    parameter int MEM_TIMEOUT = 255,
    parameter int CNT_W       = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load_inst_ex,
    input  logic             reg_we_ex,
    input  logic [4:0]       rd_ex,
    input  logic [4:0]       rs1_id,
    input  logic [4:0]       rs2_id,
    input  logic             rs1_used_id,
    input  logic             rs2_used_id,
    input  logic             redirect_ex,
    input  logic             dmem_req_mem,
    input  logic             dmem_ack,
    output logic             stall_pipe,
    output logic             stall_if_id,
    output logic             bubble_ex,
    output logic             flush_if_id,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] flush_cnt,
    output logic             mem_err
);

    typedef enum logic [1:0] {
        RUN      = 2'd0,
        MEM_WAIT = 2'd1,
        FLUSH    = 2'd2
    } state_t;

    localparam logic [3:0]  FLUSH_RELOAD = 4'(FLUSH_DEPTH - 1);
    localparam logic [16:0] WAIT_LIMIT   = 17'(MEM_TIMEOUT);

    state_t           state;
    logic [3:0]       fcnt;
    logic [15:0]      wcnt;
    logic [CNT_W-1:0] stall_cnt_q;
    logic [CNT_W-1:0] flush_cnt_q;
    logic             mem_err_q;

    logic mem_hold;
    logic load_use;
    logic rs1_hit;
    logic rs2_hit;
    logic in_flush;
    logic stall_pipe_c;
    logic stall_if_id_c;
    logic bubble_ex_c;
    logic flush_if_id_c;

    assign mem_hold = dmem_req_mem & ~dmem_ack;
    assign rs1_hit  = rs1_used_id & (rs1_id == rd_ex);
    assign rs2_hit  = rs2_used_id & (rs2_id == rd_ex);
    assign load_use = load_inst_ex & reg_we_ex & (rd_ex != 5'd0) & (rs1_hit | rs2_hit);
    assign in_flush = (state == FLUSH);

    // A frozen EX cannot act on redirect or load-use; both are re-seen on release.
    always_comb begin
        stall_pipe_c  = 1'b0;
        stall_if_id_c = 1'b0;
        bubble_ex_c   = 1'b0;
        flush_if_id_c = 1'b0;
        if (!rst) begin
            if (mem_hold) begin
                stall_pipe_c  = 1'b1;
                stall_if_id_c = 1'b1;
            end else if (in_flush || redirect_ex) begin
                flush_if_id_c = 1'b1;
            end else if (load_use) begin
                stall_if_id_c = 1'b1;
                bubble_ex_c   = 1'b1;
            end
        end
    end

    assign stall_pipe  = stall_pipe_c;
    assign stall_if_id = stall_if_id_c;
    assign bubble_ex   = bubble_ex_c;
    assign flush_if_id = flush_if_id_c;
    assign stall_cnt   = rst ? '0 : stall_cnt_q;
    assign flush_cnt   = rst ? '0 : flush_cnt_q;
    assign mem_err     = rst ? 1'b0 : mem_err_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= RUN;
            fcnt        <= 4'd0;
            wcnt        <= 16'd0;
            stall_cnt_q <= '0;
            flush_cnt_q <= '0;
            mem_err_q   <= 1'b0;
        end else begin
            if (stall_if_id_c && (stall_cnt_q != {CNT_W{1'b1}})) begin
                stall_cnt_q <= stall_cnt_q + 1'b1;
            end

            if (mem_hold) begin
                // wcnt tracks the current run of consecutive hold cycles
                if ({1'b0, wcnt} < WAIT_LIMIT) begin
                    wcnt <= wcnt + 16'd1;
                end
                if (({1'b0, wcnt} + 17'd1) >= WAIT_LIMIT) begin
                    mem_err_q <= 1'b1;
                end
                if (state == RUN) begin
                    state <= MEM_WAIT;
                end
            end else begin
                wcnt <= 16'd0;
                if (redirect_ex) begin
                    if (flush_cnt_q != {CNT_W{1'b1}}) begin
                        flush_cnt_q <= flush_cnt_q + 1'b1;
                    end
                    if (FLUSH_DEPTH > 1) begin
                        state <= FLUSH;
                        fcnt  <= FLUSH_RELOAD;
                    end else begin
                        state <= RUN;
                        fcnt  <= 4'd0;
                    end
                end else if (state == FLUSH) begin
                    if (fcnt <= 4'd1) begin
                        state <= RUN;
                        fcnt  <= 4'd0;
                    end else begin
                        fcnt <= fcnt - 4'd1;
                    end
                end else begin
                    state <= RUN;
                end
            end
        end
    end

endmodule

// File: tb/tb_ama_riscv_hazard_ctrl.sv
// tb/tb_ama_riscv_hazard_ctrl.sv - vector, sequence and random-model checks of the hazard controller
module tb_ama_riscv_hazard_ctrl;

    localparam int FD  = 3;
    localparam int TO  = 4;
    localparam int CW  = 4;
    localparam int SAT = 15;

    logic          clk = 1'b0;
    logic          rst;
    logic          load_inst_ex, reg_we_ex;
    logic [4:0]    rd_ex, rs1_id, rs2_id;
    logic          rs1_used_id, rs2_used_id;
    logic          redirect_ex, dmem_req_mem, dmem_ack;
    logic          stall_pipe, stall_if_id, bubble_ex, flush_if_id;
    logic [CW-1:0] stall_cnt, flush_cnt;
    logic          mem_err;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    ama_riscv_hazard_ctrl #(.FLUSH_DEPTH(FD), .MEM_TIMEOUT(TO), .CNT_W(CW)) dut (
        .clk(clk), .rst(rst),
        .load_inst_ex(load_inst_ex), .reg_we_ex(reg_we_ex), .rd_ex(rd_ex),
        .rs1_id(rs1_id), .rs2_id(rs2_id),
        .rs1_used_id(rs1_used_id), .rs2_used_id(rs2_used_id),
        .redirect_ex(redirect_ex), .dmem_req_mem(dmem_req_mem), .dmem_ack(dmem_ack),
        .stall_pipe(stall_pipe), .stall_if_id(stall_if_id), .bubble_ex(bubble_ex),
        .flush_if_id(flush_if_id), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt),
        .mem_err(mem_err)
    );

    typedef struct {
        logic       r, ld, we;
        logic [4:0] rd, rs1, rs2;
        logic       u1, u2, rdr, req, ack;
        logic       sp, sif, bub, fl;
        int         sc, fc;
        logic       err;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(bit r, bit ld, bit we, int rd, int rs1, int rs2, bit u1, bit u2,
                                bit rdr, bit req, bit ack, bit sp, bit sif, bit bub, bit fl,
                                int sc, int fc, bit err);
        vec_t v;
        v.r = r; v.ld = ld; v.we = we; v.rd = 5'(rd); v.rs1 = 5'(rs1); v.rs2 = 5'(rs2);
        v.u1 = u1; v.u2 = u2; v.rdr = rdr; v.req = req; v.ack = ack;
        v.sp = sp; v.sif = sif; v.bub = bub; v.fl = fl; v.sc = sc; v.fc = fc; v.err = err;
        return v;
    endfunction

    function automatic vec_t idle(bit fl, int sc, int fc, bit err);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, fl, sc, fc, err);
    endfunction

    function automatic vec_t rstv();
        return mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    endfunction

    function automatic vec_t hold(int sc, int fc, bit err);
        return mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 1, 1, 0, 0, sc, fc, err);
    endfunction

    task automatic chk(string name, logic [31:0] act, logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic drive(bit r, bit ld, bit we, int rd, int rs1, int rs2, bit u1, bit u2,
                         bit rdr, bit req, bit ack);
        rst = r; load_inst_ex = ld; reg_we_ex = we;
        rd_ex = 5'(rd); rs1_id = 5'(rs1); rs2_id = 5'(rs2);
        rs1_used_id = u1; rs2_used_id = u2;
        redirect_ex = rdr; dmem_req_mem = req; dmem_ack = ack;
    endtask

    task automatic check_all(string tag, bit sp, bit sif, bit bub, bit fl, int sc, int fc, bit err);
        chk({tag, ".stall_pipe"},  32'(stall_pipe),  32'(sp));
        chk({tag, ".stall_if_id"}, 32'(stall_if_id), 32'(sif));
        chk({tag, ".bubble_ex"},   32'(bubble_ex),   32'(bub));
        chk({tag, ".flush_if_id"}, 32'(flush_if_id), 32'(fl));
        chk({tag, ".stall_cnt"},   32'(stall_cnt),   32'(sc));
        chk({tag, ".flush_cnt"},   32'(flush_cnt),   32'(fc));
        chk({tag, ".mem_err"},     32'(mem_err),     32'(err));
    endtask

    // reference model: remaining flush cycles, current hold run length, plain counters
    int m_fleft, m_hold, m_sc, m_fc;
    bit m_err;

    task automatic model_reset();
        m_fleft = 0; m_hold = 0; m_sc = 0; m_fc = 0; m_err = 0;
    endtask

    initial begin
        vec_t v;
        bit   r, ld, we, u1, u2, rdr, req, ack, hz, lu, esp, esif, ebub, efl;
        int   rd, rs1, rs2;

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

        vecs.push_back(mk(1, 1, 1, 5, 0, 5, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 1, 1, 5, 0, 5, 0, 1, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0));
        vecs.push_back(idle(0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 5, 0, 5, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 1, 7, 7, 0, 1, 0, 0, 0, 0, 0, 1, 1, 0, 1, 0, 0));
        vecs.push_back(mk(0, 1, 0, 7, 7, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 2, 0, 0));
        vecs.push_back(rstv());
        vecs.push_back(hold(0, 0, 0));
        vecs.push_back(hold(1, 0, 0));
        vecs.push_back(hold(2, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 3, 0, 0));
        vecs.push_back(idle(0, 3, 0, 0));
        vecs.push_back(rstv());
        vecs.push_back(mk(0, 1, 1, 5, 0, 5, 0, 1, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(idle(1, 0, 1, 0));
        vecs.push_back(idle(1, 0, 1, 0));
        vecs.push_back(idle(0, 0, 1, 0));
        vecs.push_back(rstv());
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(hold(0, 1, 0));
        vecs.push_back(hold(1, 1, 0));
        vecs.push_back(idle(1, 2, 1, 0));
        vecs.push_back(idle(1, 2, 1, 0));
        vecs.push_back(idle(0, 2, 1, 0));
        vecs.push_back(rstv());
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 1, 1, 0, 0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1, 0, 0, 0, 1, 1, 0, 0));
        vecs.push_back(idle(1, 1, 1, 0));
        vecs.push_back(idle(1, 1, 1, 0));
        vecs.push_back(idle(0, 1, 1, 0));
        vecs.push_back(rstv());
        for (int k = 0; k < 6; k++) vecs.push_back(hold(k, 0, k >= 4));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 6, 0, 1));
        vecs.push_back(idle(0, 6, 0, 1));
        vecs.push_back(rstv());
        vecs.push_back(idle(0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(rstv());
        vecs.push_back(idle(0, 0, 0, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0));
        vecs.push_back(idle(1, 0, 1, 0));
        vecs.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1, 0, 1, 0));
        vecs.push_back(idle(1, 0, 2, 0));
        vecs.push_back(idle(1, 0, 2, 0));
        vecs.push_back(idle(0, 0, 2, 0));

        @(posedge clk); #1;
        for (int i = 0; i < vecs.size(); i++) begin
            v = vecs[i];
            drive(v.r, v.ld, v.we, v.rd, v.rs1, v.rs2, v.u1, v.u2, v.rdr, v.req, v.ack);
            @(negedge clk);
            check_all($sformatf("vec%0d", i), v.sp, v.sif, v.bub, v.fl, v.sc, v.fc, v.err);
            @(posedge clk); #1;
        end

        // stall counter saturation over 20 consecutive load-use cycles
        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        for (int i = 0; i < 20; i++) begin
            drive(0, 1, 1, 9, 9, 0, 1, 0, 0, 0, 0);
            @(posedge clk); #1;
        end
        drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(negedge clk);
        check_all("sat", 0, 0, 0, 0, SAT, 0, 0);
        @(posedge clk); #1;

        drive(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        @(posedge clk); #1;
        model_reset();
        req = 0;
        for (int n = 0; n < 3000; n++) begin
            r   = ($urandom_range(0, 63) == 0);
            ld  = $urandom_range(0, 1) == 1;
            we  = $urandom_range(0, 3) != 0;
            rd  = $urandom_range(0, 3);
            rs1 = $urandom_range(0, 3);
            rs2 = $urandom_range(0, 3);
            u1  = $urandom_range(0, 1) == 1;
            u2  = $urandom_range(0, 1) == 1;
            rdr = ($urandom_range(0, 7) == 0);
            req = req ? ($urandom_range(0, 7) != 0) : ($urandom_range(0, 5) == 0);
            ack = ($urandom_range(0, 3) == 0);
            drive(r, ld, we, rd, rs1, rs2, u1, u2, rdr, req, ack);
            @(negedge clk);
            if (r) begin
                check_all("rnd_rst", 0, 0, 0, 0, 0, 0, 0);
                model_reset();
            end else begin
                hz   = req && !ack;
                lu   = ld && we && (rd != 0) && ((u1 && rs1 == rd) || (u2 && rs2 == rd));
                esp  = hz;
                efl  = !hz && (m_fleft > 0 || rdr);
                ebub = !hz && !efl && lu;
                esif = hz || ebub;
                check_all("rnd", esp, esif, ebub, efl, m_sc, m_fc, m_err);
                if (esif && m_sc < SAT) m_sc++;
                if (hz) begin
                    if (m_hold < TO) m_hold++;
                    if (m_hold >= TO) m_err = 1;
                end else begin
                    m_hold = 0;
                    if (rdr) begin
                        if (m_fc < SAT) m_fc++;
                        m_fleft = FD - 1;
                    end else if (m_fleft > 0) begin
                        m_fleft--;
                    end
                end
            end
            @(posedge clk); #1;
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
